// File: rtl/arb_req_agent.sv
// Requester-side agent for a 4-way round-robin arbiter: per-client request slots plus one owner FSM
// that streams the granted client's burst onto the shared port. ARB_REQ_TIMEOUT_EN adds starvation flags.
module arb_req_agent #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          cl_valid,
    input  logic [4*LEN_W-1:0]  cl_len,
    input  logic [4*DATA_W-1:0] cl_data,
    output logic [3:0]          cl_ready,
    output logic [3:0]          cl_done,
    output logic [3:0]          req,
    input  logic [3:0]          grant,
    output logic                res_valid,
    output logic [DATA_W-1:0]   res_data,
    output logic                res_last,
    output logic [1:0]          res_owner,
    input  logic                res_ready,
    output logic                err_grant
`ifdef ARB_REQ_TIMEOUT_EN
    ,
    output logic [3:0]          starve
`endif
);

    // slot: IDLE no burst | REQ requesting | OWN streaming;  owner: FREE wait grant | BUSY beats | DRAIN req-drop gap
    typedef enum logic [1:0] {SLOT_IDLE, SLOT_REQ, SLOT_OWN} slot_state_t;
    typedef enum logic [1:0] {OWN_FREE, OWN_BUSY, OWN_DRAIN} own_state_t;

    slot_state_t       slot_q [4];
    logic [LEN_W-1:0]  len_q [4];
    logic [DATA_W-1:0] data_arr [4];
    own_state_t        own_q;
    logic [1:0]        owner_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [3:0]        done_q;
    logic              err_q;

    logic              handshake;
    logic              last_hs;
    logic              grant_one_hot;
    logic              grant_ok;
    logic              take;
    logic [1:0]        grant_idx;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("arb_req_agent: TIMEOUT must be at least 1");
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            data_arr[i] = cl_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        grant_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (grant[i]) grant_idx = 2'(i);
        end
    end

    assign grant_one_hot = (grant != 4'd0) && ((grant & (grant - 4'd1)) == 4'd0);
    assign grant_ok      = grant_one_hot && (slot_q[grant_idx] == SLOT_REQ);
    assign take          = (own_q == OWN_FREE) && grant_ok;

    assign res_valid = (own_q == OWN_BUSY);
    assign res_owner = owner_q;
    assign res_data  = res_valid ? data_arr[owner_q] : '0;
    assign res_last  = res_valid && (cnt_q == len_q[owner_q]);
    assign handshake = res_valid && res_ready;
    assign last_hs   = handshake && res_last;
    assign cl_done   = done_q;
    assign err_grant = err_q;

    always_comb begin
        cl_ready          = 4'd0;
        cl_ready[owner_q] = handshake;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req[i] = (slot_q[i] == SLOT_REQ) || (slot_q[i] == SLOT_OWN);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= SLOT_IDLE;
                len_q[i]  <= '0;
            end
            done_q <= 4'd0;
        end else begin
            done_q <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                case (slot_q[i])
                    SLOT_IDLE: begin
                        if (cl_valid[i]) begin
                            len_q[i]  <= cl_len[i*LEN_W +: LEN_W];
                            slot_q[i] <= SLOT_REQ;
                        end
                    end
                    SLOT_REQ: begin
                        if (take && (grant_idx == 2'(i))) slot_q[i] <= SLOT_OWN;
                    end
                    SLOT_OWN: begin
                        if (last_hs && (owner_q == 2'(i))) begin
                            slot_q[i] <= SLOT_IDLE;
                            done_q[i] <= 1'b1;
                        end
                    end
                    default: slot_q[i] <= SLOT_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            own_q   <= OWN_FREE;
            owner_q <= 2'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (own_q)
                OWN_FREE: begin
                    if (take) begin
                        owner_q <= grant_idx;
                        cnt_q   <= '0;
                        own_q   <= OWN_BUSY;
                    end else if (grant != 4'd0) begin
                        err_q <= 1'b1;
                    end
                end
                OWN_BUSY: begin
                    if (handshake) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (res_last) own_q <= OWN_DRAIN;
                    end
                end
                OWN_DRAIN: own_q <= OWN_FREE;
                default:   own_q <= OWN_FREE;
            endcase
        end
    end

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_q [4];
    logic [3:0]        starve_q;

    // The cycle ownership is taken does not count as waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) wait_q[i] <= '0;
            starve_q <= 4'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if ((slot_q[i] == SLOT_REQ) && !(take && (grant_idx == 2'(i)))) begin
                    if (wait_q[i] != WAIT_W'(TIMEOUT)) wait_q[i] <= wait_q[i] + WAIT_W'(1);
                    if (wait_q[i] == WAIT_W'(TIMEOUT - 1)) starve_q[i] <= 1'b1;
                end else begin
                    wait_q[i] <= '0;
                end
            end
        end
    end

    assign starve = starve_q;
`endif

endmodule

// File: tb/tb_arb_req_agent.sv
// Directed bench for arb_req_agent with a registered round-robin arbiter model and a simple client model.
module tb_arb_req_agent;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [3:0]          cl_valid = 4'd0;
    logic [4*LEN_W-1:0]  cl_len = '0;
    logic [4*DATA_W-1:0] cl_data;
    logic [3:0]          cl_ready, cl_done, req, grant;
    logic                res_valid, res_last, res_ready = 1'b0, err_grant;
    logic [DATA_W-1:0]   res_data;
    logic [1:0]          res_owner;
`ifdef ARB_REQ_TIMEOUT_EN
    logic [3:0]          starve;
`endif

    logic       arb_en = 1'b0;
    logic [3:0] man_grant = 4'd0;
    logic [3:0] arb_grant;
    logic [1:0] arb_last;
    logic [2:0] pick_w;
    logic [7:0] beat_idx [4];

    int checks = 0;
    int failures = 0;

    arb_req_agent #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cl_valid(cl_valid), .cl_len(cl_len), .cl_data(cl_data),
        .cl_ready(cl_ready), .cl_done(cl_done),
        .req(req), .grant(grant),
        .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
        .res_owner(res_owner), .res_ready(res_ready),
        .err_grant(err_grant)
`ifdef ARB_REQ_TIMEOUT_EN
        , .starve(starve)
`endif
    );

    always #5 clk = ~clk;

    // Round-robin pick after the last winner; bit 2 set means nobody requests.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = 3'b100;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) rr_pick = {1'b0, idx};
        end
    endfunction

    assign pick_w = rr_pick(req, arb_last);
    assign grant  = arb_en ? arb_grant : man_grant;

    // Registered arbiter: holds a grant while its requester keeps req high.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            arb_grant <= 4'd0;
            arb_last  <= 2'd3;
        end else if ((arb_grant == 4'd0) || ((req & arb_grant) == 4'd0)) begin
            if (!pick_w[2]) begin
                arb_grant <= 4'd1 << pick_w[1:0];
                arb_last  <= pick_w[1:0];
            end else begin
                arb_grant <= 4'd0;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) beat_idx[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cl_done[i])       beat_idx[i] <= 8'd0;
                else if (cl_ready[i]) beat_idx[i] <= beat_idx[i] + 8'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) cl_data[i*DATA_W +: DATA_W] = {16'hC0DE, 6'd0, 2'(i), beat_idx[i]};
    end

    function automatic logic [31:0] exp_data(input int c, input int b);
        return {16'hC0DE, 6'd0, c[1:0], b[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic en);
        reset = 1'b1;
        arb_en = en;
        cl_valid = 4'd0;
        cl_len = '0;
        res_ready = 1'b0;
        man_grant = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        cl_valid = 4'b1111;
        cl_len = '1;
        man_grant = 4'b0110;
        res_ready = 1'b1;
        #3;
        repeat (2) tick();
        checks++; if (req !== 4'd0) begin failures++; $display("FAIL reset_req: got %b expected 0000", req); end
        checks++; if (cl_ready !== 4'd0) begin failures++; $display("FAIL reset_cl_ready: got %b expected 0000", cl_ready); end
        checks++; if (cl_done !== 4'd0) begin failures++; $display("FAIL reset_cl_done: got %b expected 0000", cl_done); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        checks++; if (res_last !== 1'b0) begin failures++; $display("FAIL reset_res_last: got %b expected 0", res_last); end
        checks++; if (res_owner !== 2'd0) begin failures++; $display("FAIL reset_res_owner: got %0d expected 0", res_owner); end
        checks++; if (res_data !== 32'd0) begin failures++; $display("FAIL reset_res_data: got %h expected 0", res_data); end
        checks++; if (err_grant !== 1'b0) begin failures++; $display("FAIL reset_err_grant: got %b expected 0", err_grant); end
    endtask

    task automatic test_single_burst();
        do_reset(1'b1);
        cl_valid = 4'b0010;
        cl_len[1*LEN_W +: LEN_W] = 4'd2;
        res_ready = 1'b1;
        tick();
        cl_valid = 4'd0;
        checks++; if (req !== 4'b0010) begin failures++; $display("FAIL single_req_rise: got %b expected 0010", req); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid_t: got %b expected 0", res_valid); end
        tick();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid_t1: got %b expected 0", res_valid); end
        for (int b = 0; b < 3; b++) begin
            tick();
            checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL single_valid beat %0d: got %b expected 1", b, res_valid); end
            checks++; if (res_owner !== 2'd1) begin failures++; $display("FAIL single_owner beat %0d: got %0d expected 1", b, res_owner); end
            checks++; if (res_last !== (b == 2)) begin failures++; $display("FAIL single_last beat %0d: got %b expected %b", b, res_last, (b == 2)); end
            checks++; if (res_data !== exp_data(1, b)) begin failures++; $display("FAIL single_data beat %0d: got %h expected %h", b, res_data, exp_data(1, b)); end
            checks++; if (cl_ready !== 4'b0010) begin failures++; $display("FAIL single_cl_ready beat %0d: got %b expected 0010", b, cl_ready); end
            checks++; if (req !== 4'b0010) begin failures++; $display("FAIL single_req_hold beat %0d: got %b expected 0010", b, req); end
        end
        tick();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_drain_valid: got %b expected 0", res_valid); end
        checks++; if (req !== 4'd0) begin failures++; $display("FAIL single_req_drop: got %b expected 0000", req); end
        checks++; if (cl_done !== 4'b0010) begin failures++; $display("FAIL single_done_pulse: got %b expected 0010", cl_done); end
        tick();
        checks++; if (cl_done !== 4'd0) begin failures++; $display("FAIL single_done_clear: got %b expected 0000", cl_done); end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        int nhs = 0;
        int nvalid = 0;
        int done_seen = 0;
        do_reset(1'b1);
        cl_valid = 4'b0001;
        cl_len[0 +: LEN_W] = 4'd3;
        for (int cyc = 0; cyc < 40 && done_seen == 0; cyc++) begin
            tick();
            cl_valid = 4'd0;
            res_ready = pat[nvalid % 4];
            #1;
            if (cl_done[0]) done_seen = 1;
            if (res_valid) begin
                checks++; if (res_data !== exp_data(0, nhs)) begin failures++; $display("FAIL bp_data valid %0d: got %h expected %h", nvalid, res_data, exp_data(0, nhs)); end
                checks++; if (res_last !== (nhs == 3)) begin failures++; $display("FAIL bp_last valid %0d: got %b expected %b", nvalid, res_last, (nhs == 3)); end
                checks++; if (cl_ready !== (res_ready ? 4'b0001 : 4'b0000)) begin failures++; $display("FAIL bp_cl_ready valid %0d: got %b expected %b", nvalid, cl_ready, {3'b000, res_ready}); end
                if (res_ready) nhs++;
                nvalid++;
            end
        end
        checks++; if (nhs != 4) begin failures++; $display("FAIL bp_handshakes: got %0d expected 4", nhs); end
        checks++; if (nvalid != 8) begin failures++; $display("FAIL bp_valid_cycles: got %0d expected 8", nvalid); end
        checks++; if (done_seen != 1) begin failures++; $display("FAIL bp_done: got %0d expected 1", done_seen); end
    endtask

    task automatic test_contention();
        int nhs = 0;
        int last0 = -1;
        int first3 = -1;
        int done0 = 0;
        int done3 = 0;
        int eo;
        do_reset(1'b1);
        res_ready = 1'b1;
        cl_valid = 4'b1001;
        cl_len[0 +: LEN_W] = 4'd1;
        cl_len[3*LEN_W +: LEN_W] = 4'd2;
        for (int cyc = 0; cyc < 40 && done3 == 0; cyc++) begin
            tick();
            cl_valid = 4'd0;
            if (cl_done[0]) done0++;
            if (cl_done[3]) done3++;
            if (res_valid) begin
                eo = (nhs < 2) ? 0 : 3;
                checks++; if (res_owner !== 2'(eo)) begin failures++; $display("FAIL cont_owner hs %0d: got %0d expected %0d", nhs, res_owner, eo); end
                checks++; if (cl_ready !== (4'd1 << eo)) begin failures++; $display("FAIL cont_cl_ready hs %0d: got %b expected %b", nhs, cl_ready, 4'd1 << eo); end
                checks++; if (res_data !== exp_data(eo, (eo == 0) ? nhs : nhs - 2)) begin failures++; $display("FAIL cont_data hs %0d: got %h expected %h", nhs, res_data, exp_data(eo, (eo == 0) ? nhs : nhs - 2)); end
                checks++; if (res_last !== ((nhs == 1) || (nhs == 4))) begin failures++; $display("FAIL cont_last hs %0d: got %b expected %b", nhs, res_last, ((nhs == 1) || (nhs == 4))); end
                if (eo == 0) last0 = cyc;
                if (nhs == 2) first3 = cyc;
                nhs++;
            end
        end
        checks++; if (nhs != 5) begin failures++; $display("FAIL cont_handshakes: got %0d expected 5", nhs); end
        // DRAIN, then FREE while the arbiter's registered grant rotates to client 3.
        checks++; if (first3 - last0 != 3) begin failures++; $display("FAIL cont_gap: got %0d expected 3", first3 - last0); end
        checks++; if (done0 != 1) begin failures++; $display("FAIL cont_done0: got %0d expected 1", done0); end
        checks++; if (done3 != 1) begin failures++; $display("FAIL cont_done3: got %0d expected 1", done3); end
        checks++; if (err_grant !== 1'b0) begin failures++; $display("FAIL cont_err: got %b expected 0", err_grant); end
    endtask

    task automatic test_protocol_error();
        do_reset(1'b0);
        man_grant = 4'b0110;
        tick();
        checks++; if (err_grant !== 1'b1) begin failures++; $display("FAIL perr_multi: got %b expected 1", err_grant); end
        man_grant = 4'd0;
        repeat (3) tick();
        checks++; if (err_grant !== 1'b1) begin failures++; $display("FAIL perr_sticky: got %b expected 1", err_grant); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL perr_multi_valid: got %b expected 0", res_valid); end
        do_reset(1'b0);
        checks++; if (err_grant !== 1'b0) begin failures++; $display("FAIL perr_cleared: got %b expected 0", err_grant); end
        man_grant = 4'b0100;
        tick();
        checks++; if (err_grant !== 1'b1) begin failures++; $display("FAIL perr_idle_slot: got %b expected 1", err_grant); end
        man_grant = 4'd0;
        tick();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL perr_idle_valid: got %b expected 0", res_valid); end
        checks++; if (req !== 4'd0) begin failures++; $display("FAIL perr_idle_req: got %b expected 0000", req); end
    endtask

    task automatic test_reset_mid_burst();
        int nhs = 0;
        int hit = 0;
        int dones = 0;
        do_reset(1'b1);
        res_ready = 1'b1;
        cl_valid = 4'b0100;
        cl_len[2*LEN_W +: LEN_W] = 4'd5;
        for (int cyc = 0; cyc < 20 && hit == 0; cyc++) begin
            tick();
            cl_valid = 4'd0;
            if (res_valid) begin
                if (nhs == 1) hit = 1;
                else nhs++;
            end
        end
        checks++; if (hit != 1) begin failures++; $display("FAIL rmb_reach_beat2: got %0d expected 1", hit); end
        reset = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rmb_valid: got %b expected 0", res_valid); end
        checks++; if (req !== 4'd0) begin failures++; $display("FAIL rmb_req: got %b expected 0000", req); end
        checks++; if (cl_ready !== 4'd0) begin failures++; $display("FAIL rmb_cl_ready: got %b expected 0000", cl_ready); end
        checks++; if (res_data !== 32'd0) begin failures++; $display("FAIL rmb_data: got %h expected 0", res_data); end
        checks++; if (res_owner !== 2'd0) begin failures++; $display("FAIL rmb_owner: got %0d expected 0", res_owner); end
        tick();
        tick();
        reset = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            tick();
            if (cl_done !== 4'd0) dones++;
        end
        checks++; if (dones != 0) begin failures++; $display("FAIL rmb_no_done: got %0d expected 0", dones); end
        nhs = 0;
        cl_valid = 4'b0100;
        cl_len[2*LEN_W +: LEN_W] = 4'd1;
        for (int cyc = 0; cyc < 20 && dones == 0; cyc++) begin
            tick();
            cl_valid = 4'd0;
            if (cl_done[2]) dones++;
            if (res_valid) begin
                checks++; if (res_data !== exp_data(2, nhs)) begin failures++; $display("FAIL rmb_new_data hs %0d: got %h expected %h", nhs, res_data, exp_data(2, nhs)); end
                nhs++;
            end
        end
        checks++; if (nhs != 2) begin failures++; $display("FAIL rmb_new_beats: got %0d expected 2", nhs); end
        checks++; if (dones != 1) begin failures++; $display("FAIL rmb_new_done: got %0d expected 1", dones); end
    endtask

`ifdef ARB_REQ_TIMEOUT_EN
    task automatic test_timeout();
        do_reset(1'b0);
        res_ready = 1'b1;
        cl_valid = 4'b0100;
        tick();
        cl_valid = 4'd0;
        repeat (7) tick();
        checks++; if (starve !== 4'd0) begin failures++; $display("FAIL to_before_limit: got %b expected 0000", starve); end
        tick();
        checks++; if (starve !== 4'b0100) begin failures++; $display("FAIL to_at_limit: got %b expected 0100", starve); end
        man_grant = 4'b0100;
        tick();
        man_grant = 4'd0;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL to_late_own: got %b expected 1", res_valid); end
        repeat (2) tick();
        checks++; if (starve !== 4'b0100) begin failures++; $display("FAIL to_sticky: got %b expected 0100", starve); end
        do_reset(1'b0);
        res_ready = 1'b1;
        cl_valid = 4'b0100;
        tick();
        cl_valid = 4'd0;
        repeat (6) tick();
        man_grant = 4'b0100;
        tick();
        man_grant = 4'd0;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL to_cycle7_own: got %b expected 1", res_valid); end
        repeat (8) tick();
        checks++; if (starve !== 4'd0) begin failures++; $display("FAIL to_cycle7_no_starve: got %b expected 0000", starve); end
        checks++; if (err_grant !== 1'b0) begin failures++; $display("FAIL to_err: got %b expected 0", err_grant); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the bench completed");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_burst();
        test_backpressure();
        test_contention();
        test_protocol_error();
        test_reset_mid_burst();
`ifdef ARB_REQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
